// File: rtl/spiking_activation_array.sv
// Multi-channel spiking activation stage: per-channel leaky integrate-and-fire
// neurons with selectable post-spike reset, refractory period and saturating
// spike counters. One result vector per accepted step, one cycle later.
// Optional linear leak is enabled by defining SPIKING_ACTIVATION_LEAK_EN;
// without it the leak port is ignored and sub-threshold steps keep v = sum.
module spiking_activation_array #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned REFRACT_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  clear,
  input  logic                                  in_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    in_current,
  input  logic [DATA_WIDTH-1:0]                 threshold,
  input  logic [DATA_WIDTH-1:0]                 leak,
  input  logic                                  reset_mode,
  input  logic [REFRACT_WIDTH-1:0]              refractory_cycles,
  output logic                                  out_valid,
  output logic [NUM_CHANNELS-1:0]               spike,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]   accumulated_spikes,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    membrane_potential
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned NC = NUM_CHANNELS;
  localparam int unsigned CW = COUNT_WIDTH;
  localparam int unsigned RW = REFRACT_WIDTH;

  // Clamp a DW+1-bit two's-complement value into the signed DW-bit range.
  function automatic logic [DW-1:0] sat(input logic [DW:0] x);
    if (x[DW] != x[DW-1]) begin
      sat = x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat = x[DW-1:0];
    end
  endfunction

  logic [DW-1:0] v_q   [NC];
  logic [RW-1:0] r_q   [NC];
  logic [CW-1:0] cnt_q [NC];
  logic [DW-1:0] v_d   [NC];
  logic [RW-1:0] r_d   [NC];
  logic [CW-1:0] cnt_d [NC];
  logic [DW-1:0] cur_w [NC];
  logic [DW-1:0] sum_w [NC];
  logic [NC-1:0] spk_d;
  logic [DW-1:0] leak_eff;

`ifdef SPIKING_ACTIVATION_LEAK_EN
  // Negative leak values would pump charge in, so they are clamped to zero.
  assign leak_eff = leak[DW-1] ? '0 : leak;
`else
  logic unused_leak;
  assign leak_eff    = '0;
  assign unused_leak = ^leak;
`endif

  // Per-channel next state for a valid step: refractory hold, integrate, fire.
  always_comb begin
    spk_d = '0;
    for (int i = 0; i < NC; i++) begin
      cur_w[i] = in_current[i*DW +: DW];
      sum_w[i] = sat({v_q[i][DW-1], v_q[i]} + {cur_w[i][DW-1], cur_w[i]});
      v_d[i]   = v_q[i];
      r_d[i]   = r_q[i];
      cnt_d[i] = cnt_q[i];
      if (r_q[i] != '0) begin
        r_d[i] = r_q[i] - RW'(1);
      end else if ($signed(sum_w[i]) >= $signed(threshold)) begin
        spk_d[i] = 1'b1;
        r_d[i]   = refractory_cycles;
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CW'(1);
        v_d[i]   = reset_mode ? sat({sum_w[i][DW-1], sum_w[i]} - {threshold[DW-1], threshold})
                              : '0;
      end else begin
        v_d[i] = sat({sum_w[i][DW-1], sum_w[i]} - {1'b0, leak_eff});
      end
    end
  end

  // State and output registers; clear beats a same-cycle valid step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      spike     <= '0;
      for (int i = 0; i < NC; i++) begin
        v_q[i]   <= '0;
        r_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else if (clear) begin
      out_valid <= 1'b0;
      spike     <= '0;
      for (int i = 0; i < NC; i++) begin
        v_q[i]   <= '0;
        r_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else if (in_valid) begin
      out_valid <= 1'b1;
      spike     <= spk_d;
      for (int i = 0; i < NC; i++) begin
        v_q[i]   <= v_d[i];
        r_q[i]   <= r_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end else begin
      out_valid <= 1'b0;
      spike     <= '0;
    end
  end

  // Pack the registered per-channel state onto the output buses.
  always_comb begin
    membrane_potential = '0;
    accumulated_spikes = '0;
    for (int i = 0; i < NC; i++) begin
      membrane_potential[i*DW +: DW] = v_q[i];
      accumulated_spikes[i*CW +: CW] = cnt_q[i];
    end
  end

endmodule
